// File: rtl/icg_sleep_ctrl.sv
// Per-channel clock-gate controller for negative-edge ICG cells: wakes on request, ACKs after a
// programmable delay, re-gates after an idle hold-off. E/ACK/ALL_OFF are registered; TE follows SE.
module icg_sleep_ctrl #(
  parameter int NCH = 4,
  parameter int CW  = 4
) (
  input  logic           clk_i,
  input  logic           rn_i,
  input  logic [NCH-1:0] req_i,
  input  logic [NCH-1:0] force_on_i,
  input  logic [CW-1:0]  wake_cfg_i,
  input  logic [CW-1:0]  idle_cfg_i,
  input  logic           se_i,
  output logic [NCH-1:0] e_o,
  output logic [NCH-1:0] te_o,
  output logic [NCH-1:0] ack_o,
  output logic           all_off_o
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [NCH-1:0] e_q, e_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic           all_off_q, all_off_d;
  logic [NCH-1:0] req_eff;

  assign req_eff = req_i | force_on_i;

  always_comb begin
    all_off_d = 1'b1;
    e_d       = '0;
    ack_d     = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_OFF: begin
          if (req_eff[i]) begin
            state_d[i] = ST_WAKE;
            cnt_d[i]   = wake_cfg_i;
          end
        end
        // A request dropped during wake is ignored; the requester always sees ACK once.
        ST_WAKE: begin
          if (cnt_q[i] == '0) state_d[i] = ST_ON;
          else                cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        ST_ON: begin
          if (!req_eff[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = idle_cfg_i;
          end
        end
        ST_IDLE: begin
          if (req_eff[i])            state_d[i] = ST_ON;
          else if (cnt_q[i] == '0)   state_d[i] = ST_OFF;
          else                       cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
      e_d[i]   = (state_d[i] != ST_OFF);
      ack_d[i] = (state_d[i] == ST_ON);
      if (state_d[i] != ST_OFF) all_off_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      e_q       <= '0;
      ack_q     <= '0;
      all_off_q <= 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      e_q       <= e_d;
      ack_q     <= ack_d;
      all_off_q <= all_off_d;
    end
  end

  assign e_o       = e_q;
  assign ack_o     = ack_q;
  assign all_off_o = all_off_q;
  assign te_o      = {NCH{se_i}};

endmodule

// File: tb/tb_icg_sleep_ctrl.sv
// Directed, table-driven bench for icg_sleep_ctrl (NCH=4, CW=4).
module tb_icg_sleep_ctrl;

  localparam int NCH = 4;
  localparam int CW  = 4;

  logic           clk_i = 1'b0;
  logic           rn_i;
  logic [NCH-1:0] req_i, force_on_i;
  logic [CW-1:0]  wake_cfg_i, idle_cfg_i;
  logic           se_i;
  logic [NCH-1:0] e_o, te_o, ack_o;
  logic           all_off_o;

  int errors = 0;
  int checks = 0;

  icg_sleep_ctrl #(.NCH(NCH), .CW(CW)) dut (
    .clk_i      (clk_i),
    .rn_i       (rn_i),
    .req_i      (req_i),
    .force_on_i (force_on_i),
    .wake_cfg_i (wake_cfg_i),
    .idle_cfg_i (idle_cfg_i),
    .se_i       (se_i),
    .e_o        (e_o),
    .te_o       (te_o),
    .ack_o      (ack_o),
    .all_off_o  (all_off_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [NCH-1:0] req;
    logic [NCH-1:0] frc;
    logic [CW-1:0]  wcfg;
    logic [CW-1:0]  icfg;
    logic           se;
    logic [NCH-1:0] exp_e;
    logic [NCH-1:0] exp_ack;
    logic           exp_aoff;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] req, input logic [3:0] frc, input logic [3:0] wcfg,
                     input logic [3:0] icfg, input logic se, input logic [3:0] e,
                     input logic [3:0] ack, input logic aoff);
    vec_t v;
    v.req = req; v.frc = frc; v.wcfg = wcfg; v.icfg = icfg; v.se = se;
    v.exp_e = e; v.exp_ack = ack; v.exp_aoff = aoff;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e, input logic [3:0] ack,
                            input logic aoff, input logic [3:0] te);
    check({tag, " E"},       32'(e_o),       32'(e));
    check({tag, " ACK"},     32'(ack_o),     32'(ack));
    check({tag, " ALL_OFF"}, 32'(all_off_o), 32'(aoff));
    check({tag, " TE"},      32'(te_o),      32'(te));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rn_i = 1'b0; req_i = '0; force_on_i = '0; wake_cfg_i = '0; idle_cfg_i = '0; se_i = 1'b0;
    #12;
    check_outs("reset", 4'b0000, 4'b0000, 1'b1, 4'b0000);
    #6 rn_i = 1'b1;

    //   req     frc     wcfg  icfg  se    e       ack     aoff
    // wake latency WAKE_CFG=3 then idle hold-off IDLE_CFG=2 on ch0
    add(4'b0000, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0000, 4'b0000, 1'b1);
    add(4'b0001, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0001, 4'b0000, 1'b0);
    add(4'b0001, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0001, 4'b0000, 1'b0);
    add(4'b0001, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0001, 4'b0000, 1'b0);
    add(4'b0001, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0001, 4'b0000, 1'b0);
    add(4'b0001, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0001, 4'b0001, 1'b0);
    add(4'b0000, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0001, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0001, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0001, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'd3, 4'd2, 1'b0, 4'b0000, 4'b0000, 1'b1);
    // ch2: re-request during IDLE_CFG=5, then IDLE_CFG=0 release
    add(4'b0100, 4'b0000, 4'd0, 4'd5, 1'b0, 4'b0100, 4'b0000, 1'b0);
    add(4'b0100, 4'b0000, 4'd0, 4'd5, 1'b0, 4'b0100, 4'b0100, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd5, 1'b0, 4'b0100, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd5, 1'b0, 4'b0100, 4'b0000, 1'b0);
    add(4'b0100, 4'b0000, 4'd0, 4'd5, 1'b0, 4'b0100, 4'b0100, 1'b0);
    add(4'b0100, 4'b0000, 4'd0, 4'd5, 1'b0, 4'b0100, 4'b0100, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd0, 1'b0, 4'b0100, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd0, 1'b0, 4'b0000, 4'b0000, 1'b1);
    // ch3: one-cycle pulse with zero configs -> E 3 cycles, ACK 1 cycle
    add(4'b1000, 4'b0000, 4'd0, 4'd0, 1'b0, 4'b1000, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd0, 1'b0, 4'b1000, 4'b1000, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd0, 1'b0, 4'b1000, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd0, 1'b0, 4'b0000, 4'b0000, 1'b1);
    // ch0 forced on, scan enable toggles without affecting state
    add(4'b0000, 4'b0001, 4'd1, 4'd0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    add(4'b0000, 4'b0001, 4'd1, 4'd0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    add(4'b0000, 4'b0001, 4'd1, 4'd0, 1'b0, 4'b0001, 4'b0001, 1'b0);
    add(4'b0000, 4'b0001, 4'd1, 4'd0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    add(4'b0000, 4'b0001, 4'd1, 4'd0, 1'b0, 4'b0001, 4'b0001, 1'b0);
    // ch1 wake with WAKE_CFG=2 changed to 0 mid-count; then both released with IDLE_CFG=1
    add(4'b0010, 4'b0001, 4'd2, 4'd1, 1'b0, 4'b0011, 4'b0001, 1'b0);
    add(4'b0010, 4'b0001, 4'd0, 4'd1, 1'b0, 4'b0011, 4'b0001, 1'b0);
    add(4'b0010, 4'b0001, 4'd0, 4'd1, 1'b0, 4'b0011, 4'b0001, 1'b0);
    add(4'b0010, 4'b0001, 4'd0, 4'd1, 1'b0, 4'b0011, 4'b0011, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd1, 1'b0, 4'b0011, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd1, 1'b0, 4'b0011, 4'b0000, 1'b0);
    add(4'b0000, 4'b0000, 4'd0, 4'd1, 1'b0, 4'b0000, 4'b0000, 1'b1);

    for (int v = 0; v < vecs.size(); v++) begin
      req_i = vecs[v].req; force_on_i = vecs[v].frc; wake_cfg_i = vecs[v].wcfg;
      idle_cfg_i = vecs[v].icfg; se_i = vecs[v].se;
      step();
      check_outs($sformatf("vec%0d", v), vecs[v].exp_e, vecs[v].exp_ack, vecs[v].exp_aoff,
                 {4{vecs[v].se}});
    end

    // Max count: CFG=15 gives 16 WAKE cycles and 16 IDLE cycles on ch1
    wake_cfg_i = 4'd15; idle_cfg_i = 4'd15; req_i = 4'b0010;
    for (int c = 0; c < 16; c++) begin
      step();
      check_outs($sformatf("maxwake%0d", c), 4'b0010, 4'b0000, 1'b0, 4'b0000);
    end
    step();
    check_outs("maxwake_ack", 4'b0010, 4'b0010, 1'b0, 4'b0000);
    req_i = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      step();
      check_outs($sformatf("maxidle%0d", c), 4'b0010, 4'b0000, 1'b0, 4'b0000);
    end
    step();
    check_outs("maxidle_off", 4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Combinational TE between edges
    #2 se_i = 1'b1;
    #1 check_outs("te_mid_hi", 4'b0000, 4'b0000, 1'b1, 4'b1111);
    se_i = 1'b0;
    #1 check_outs("te_mid_lo", 4'b0000, 4'b0000, 1'b1, 4'b0000);

    // Async reset mid-ON with REQ held, then restart after release
    wake_cfg_i = 4'd0; idle_cfg_i = 4'd0; req_i = 4'b0001;
    step(); step();
    check_outs("pre_reset_on", 4'b0001, 4'b0001, 1'b0, 4'b0000);
    #2 rn_i = 1'b0;
    #1 check_outs("async_reset", 4'b0000, 4'b0000, 1'b1, 4'b0000);
    @(negedge clk_i) rn_i = 1'b1;
    step();
    check_outs("post_reset_wake", 4'b0001, 4'b0000, 1'b0, 4'b0000);
    step();
    check_outs("post_reset_on", 4'b0001, 4'b0001, 1'b0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
